gmii_tx_framer: RTL and testbench

Transmit-side MAC framer that turns a byte stream with a valid/ready handshake into a complete Ethernet frame on the 8-bit GMII-style bus (mac_txv/mac_txd). The frame is preamble, SFD, payload, zero padding, FCS, then inter-frame gap. It runs in the mac_txc domain and feeds the RGMII DDR output stage, which serialises mac_txd onto rgmii_txd. It is the transmit counterpart of the RGMII receive path.

---
 rtl/gmii_pkg.sv | 27 ++
 rtl/crc32_d8.sv | 31 +++
 rtl/gmii_tx_framer.sv | 157 +++++++++++++++
 tb/tb_gmii_tx_framer.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/gmii_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gmii_pkg
// Description : Shared constants and FSM state encoding for the GMII transmit
//               framer and its CRC helper.
// Revision    : 1.0 - initial release
// ============================================================================
package gmii_pkg;

    localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE      = 8'hD5;
    localparam logic [31:0] CRC_POLY      = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT      = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_RESIDUE   = 32'hDEBB20E3;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PREAMBLE = 3'd1,
        ST_SFD      = 3'd2,
        ST_DATA     = 3'd3,
        ST_PAD      = 3'd4,
        ST_FCS      = 3'd5,
        ST_IFG      = 3'd6
    } tx_state_t;

endpackage
`default_nettype wire

// File: rtl/crc32_d8.sv
`default_nettype none
// ============================================================================
// Module      : crc32_d8
// Description : Byte-wide combinational IEEE 802.3 CRC-32 next-state
//               (reflected, LSB of data_in first).
// Revision    : 1.0 - initial release
// ============================================================================
module crc32_d8
    import gmii_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [7:0]  data_in,
    output logic [31:0] crc_out
);

    logic [31:0] w_crc;

    always_comb begin
        w_crc = crc_in;
        for (int i = 0; i < 8; i++) begin
            if (w_crc[0] ^ data_in[i]) begin
                w_crc = (w_crc >> 1) ^ CRC_POLY;
            end else begin
                w_crc = w_crc >> 1;
            end
        end
        crc_out = w_crc;
    end

endmodule
`default_nettype wire

// File: rtl/gmii_tx_framer.sv
`default_nettype none
// ============================================================================
// Module      : gmii_tx_framer
// Description : Transmit MAC framer: preamble, SFD, payload, zero pad, FCS and
//               inter-frame gap onto an 8-bit GMII bus. FCS generation is
//               built only when GMII_TX_FCS_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module gmii_tx_framer
    import gmii_pkg::*;
#(
    parameter int MIN_FRAME    = 60,
    parameter int PREAMBLE_LEN = 7,
    parameter int IFG_CYCLES   = 12
) (
    input  logic       mac_txc,
    input  logic       rst,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    input  logic       tx_last,
    output logic       tx_ready,
    output logic       mac_txv,
    output logic [7:0] mac_txd,
    output logic       tx_busy,
    output logic       tx_underrun
);

    localparam logic [10:0] c_MIN_CNT  = 11'(MIN_FRAME);
    localparam logic [7:0]  c_PRE_LAST = 8'(PREAMBLE_LEN);
    localparam logic [7:0]  c_IFG_LAST = 8'(IFG_CYCLES - 1);
`ifdef GMII_TX_FCS_EN
    localparam tx_state_t   c_END_STATE = ST_FCS;
`else
    localparam tx_state_t   c_END_STATE = ST_IFG;
`endif

    tx_state_t   r_state;
    logic [10:0] r_byte_cnt;
    logic [7:0]  r_aux_cnt;
    logic [10:0] w_cnt_inc;

    // SFD cycle already accepts: the first payload byte lands right after 0xD5.
    assign tx_ready  = (r_state == ST_SFD) || (r_state == ST_DATA);
    assign tx_busy   = (r_state != ST_IDLE);
    assign w_cnt_inc = (r_byte_cnt == 11'h7FF) ? r_byte_cnt : r_byte_cnt + 11'd1;

`ifdef GMII_TX_FCS_EN
    logic [31:0] r_crc;
    logic [31:0] w_crc_next;
    logic [31:0] w_fcs;
    logic [7:0]  w_crc_byte;

    assign w_crc_byte = (r_state == ST_PAD) ? 8'h00 : tx_data;
    assign w_fcs      = ~r_crc;

    crc32_d8 u_crc32_d8 (
        .crc_in  (r_crc),
        .data_in (w_crc_byte),
        .crc_out (w_crc_next)
    );

    always_ff @(posedge mac_txc) begin
        if (rst || r_state == ST_IDLE) begin
            r_crc <= CRC_INIT;
        end else if ((tx_valid && tx_ready) || r_state == ST_PAD) begin
            r_crc <= w_crc_next;
        end
    end
`endif

    always_ff @(posedge mac_txc) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_byte_cnt  <= 11'd0;
            r_aux_cnt   <= 8'd0;
            mac_txv     <= 1'b0;
            mac_txd     <= 8'h00;
            tx_underrun <= 1'b0;
        end else begin
            tx_underrun <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    mac_txv    <= 1'b0;
                    mac_txd    <= 8'h00;
                    r_byte_cnt <= 11'd0;
                    r_aux_cnt  <= 8'd0;
                    if (tx_valid) begin
                        r_state   <= ST_PREAMBLE;
                        mac_txv   <= 1'b1;
                        mac_txd   <= PREAMBLE_BYTE;
                        r_aux_cnt <= 8'd1;
                    end
                end
                ST_PREAMBLE: begin
                    if (r_aux_cnt < c_PRE_LAST) begin
                        mac_txd   <= PREAMBLE_BYTE;
                        r_aux_cnt <= r_aux_cnt + 8'd1;
                    end else begin
                        mac_txd   <= SFD_BYTE;
                        r_aux_cnt <= 8'd0;
                        r_state   <= ST_SFD;
                    end
                end
                ST_SFD, ST_DATA: begin
                    if (tx_valid) begin
                        mac_txd    <= tx_data;
                        r_byte_cnt <= w_cnt_inc;
                        r_state    <= ST_DATA;
                        if (tx_last) begin
                            r_state <= (w_cnt_inc < c_MIN_CNT) ? ST_PAD : c_END_STATE;
                        end
                    end else begin
                        // Starved source: abandon the frame, no pad or FCS.
                        mac_txv     <= 1'b0;
                        mac_txd     <= 8'h00;
                        tx_underrun <= 1'b1;
                        r_aux_cnt   <= 8'd0;
                        r_state     <= ST_IFG;
                    end
                end
                ST_PAD: begin
                    mac_txd    <= 8'h00;
                    r_byte_cnt <= w_cnt_inc;
                    if (w_cnt_inc >= c_MIN_CNT) begin
                        r_state <= c_END_STATE;
                    end
                end
`ifdef GMII_TX_FCS_EN
                ST_FCS: begin
                    mac_txd   <= 8'(w_fcs >> {r_aux_cnt[1:0], 3'b000});
                    r_aux_cnt <= r_aux_cnt + 8'd1;
                    if (r_aux_cnt[1:0] == 2'd3) begin
                        r_aux_cnt <= 8'd0;
                        r_state   <= ST_IFG;
                    end
                end
`endif
                ST_IFG: begin
                    mac_txv   <= 1'b0;
                    mac_txd   <= 8'h00;
                    r_aux_cnt <= r_aux_cnt + 8'd1;
                    if (r_aux_cnt == c_IFG_LAST) begin
                        r_aux_cnt <= 8'd0;
                        r_state   <= ST_IDLE;
                    end
                end
                default: begin
                    mac_txv <= 1'b0;
                    mac_txd <= 8'h00;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_gmii_tx_framer.sv
`default_nettype none
// ============================================================================
// Module      : tb_gmii_tx_framer
// Description : Directed self-checking bench for gmii_tx_framer and crc32_d8.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gmii_tx_framer;

`ifdef GMII_TX_FCS_EN
    localparam int FCS_BYTES = 4;
`else
    localparam int FCS_BYTES = 0;
`endif

    logic       mac_txc;
    logic       rst;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_last;
    logic       tx_ready;
    logic       mac_txv;
    logic [7:0] mac_txd;
    logic       tx_busy;
    logic       tx_underrun;

    logic [31:0] ref_in;
    logic [7:0]  ref_d;
    logic [31:0] ref_out;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] pay [0:255];
    logic [7:0] cap_q [$];
    int  idle_cnt = 0;
    int  last_gap = -1;
    int  und_cnt  = 0;
    bit  prev_txv = 1'b0;

    gmii_tx_framer #(
        .MIN_FRAME    (60),
        .PREAMBLE_LEN (7),
        .IFG_CYCLES   (12)
    ) u_dut (
        .mac_txc     (mac_txc),
        .rst         (rst),
        .tx_valid    (tx_valid),
        .tx_data     (tx_data),
        .tx_last     (tx_last),
        .tx_ready    (tx_ready),
        .mac_txv     (mac_txv),
        .mac_txd     (mac_txd),
        .tx_busy     (tx_busy),
        .tx_underrun (tx_underrun)
    );

    crc32_d8 u_crc_ref (
        .crc_in  (ref_in),
        .data_in (ref_d),
        .crc_out (ref_out)
    );

    initial mac_txc = 1'b0;
    always #4 mac_txc = ~mac_txc;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // Wire monitor: collects transmitted bytes and idle-gap lengths.
    always @(negedge mac_txc) begin
        if (mac_txv) begin
            if (!prev_txv) last_gap = idle_cnt;
            idle_cnt = 0;
            cap_q.push_back(mac_txd);
        end else begin
            idle_cnt++;
        end
        prev_txv = mac_txv;
        if (tx_underrun) und_cnt++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c;
        for (int k = 0; k < 8; k++) begin
            if (r[0] ^ b[k]) r = (r >> 1) ^ 32'hEDB88320;
            else             r = r >> 1;
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge mac_txc);
        #1;
    endtask

    // Drives n bytes of pay[]; lat counts cycles before tx_ready first rises.
    task automatic send_payload(input int n, input bit give_last, input bit hold, output int lat);
        int  idx;
        int  guard;
        bit  rdy;
        idx   = 0;
        guard = 0;
        lat   = 0;
        tx_valid = 1'b1;
        tx_data  = pay[0];
        tx_last  = give_last && (n == 1);
        while (idx < n && guard < 3000) begin
            @(negedge mac_txc);
            rdy = tx_ready;
            if (!rdy && idx == 0) lat++;
            @(posedge mac_txc);
            #1;
            guard++;
            if (rdy) begin
                idx++;
                if (idx < n) begin
                    tx_data = pay[idx];
                    tx_last = give_last && (idx == n - 1);
                end
            end
        end
        tx_last  = 1'b0;
        tx_valid = hold;
        check_eq("accepted", 32'(idx), 32'(n));
    endtask

    task automatic wait_frame_done(input string tag);
        int g;
        g = 0;
        while (g < 400) begin
            @(negedge mac_txc);
            if (!mac_txv) break;
            g++;
        end
        check_eq({tag, "_end"}, 32'(mac_txv), 32'd0);
    endtask

    task automatic check_frame(input string tag, input int n, input bit complete);
        logic [7:0]  exp_q [$];
        logic [31:0] crc;
        int cnt;
        int bad;
        for (int i = 0; i < 7; i++) exp_q.push_back(8'h55);
        exp_q.push_back(8'hD5);
        for (int i = 0; i < n; i++) exp_q.push_back(pay[i]);
        cnt = n;
        if (complete) begin
            while (cnt < 60) begin
                exp_q.push_back(8'h00);
                cnt++;
            end
        end
        check_eq({tag, "_len"}, 32'(cap_q.size()),
                 32'(exp_q.size() + (complete ? FCS_BYTES : 0)));
        bad = 0;
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i >= cap_q.size()) bad++;
            else if (cap_q[i] !== exp_q[i]) bad++;
        end
        check_eq({tag, "_bytes"}, 32'(bad), 32'd0);
`ifdef GMII_TX_FCS_EN
        if (complete) begin
            crc = 32'hFFFF_FFFF;
            for (int i = 8; i < cap_q.size(); i++) crc = crc_byte(crc, cap_q[i]);
            check_eq({tag, "_residue"}, crc, 32'hDEBB20E3);
        end
`else
        crc = 32'd0;
`endif
        cap_q.delete();
    endtask

    initial begin
        int lat;
        int busy_n;
        rst      = 1'b1;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        tx_last  = 1'b0;
        ref_in   = 32'hFFFF_FFFF;
        ref_d    = 8'h00;
        repeat (3) tick();
        check_eq("rst_txv",   32'(mac_txv),     32'd0);
        check_eq("rst_txd",   32'(mac_txd),     32'd0);
        check_eq("rst_ready", 32'(tx_ready),    32'd0);
        check_eq("rst_busy",  32'(tx_busy),     32'd0);
        check_eq("rst_under", 32'(tx_underrun), 32'd0);
        rst = 1'b0;
        repeat (2) tick();
        cap_q.delete();

        // Single-byte frame: padded to 60
        pay[0] = 8'hAB;
        send_payload(1, 1'b1, 1'b0, lat);
        check_eq("a_ready_lat", 32'(lat), 32'd8);
        wait_frame_done("a");
        check_frame("a", 1, 1'b1);
        repeat (20) tick();

        // 100-byte frame, then back-to-back 3-byte frame with tx_valid held
        for (int i = 0; i < 100; i++) pay[i] = 8'(i);
        send_payload(100, 1'b1, 1'b1, lat);
        wait_frame_done("b");
        check_frame("b", 100, 1'b1);
        pay[0] = 8'h11; pay[1] = 8'h22; pay[2] = 8'h33;
        send_payload(3, 1'b1, 1'b0, lat);
        wait_frame_done("c");
        check_eq("c_gap", 32'(last_gap), 32'd12);
        check_frame("c", 3, 1'b1);
        check_eq("no_underrun", 32'(und_cnt), 32'd0);
        repeat (20) tick();

        // Underrun after 10 bytes
        for (int i = 0; i < 10; i++) pay[i] = 8'hA0 + 8'(i);
        send_payload(10, 1'b0, 1'b0, lat);
        wait_frame_done("und");
        check_frame("und", 10, 1'b0);
        busy_n = 0;
        while (tx_busy && busy_n < 100) begin
            busy_n++;
            @(negedge mac_txc);
        end
        check_eq("und_ifg", 32'(busy_n), 32'd12);
        check_eq("und_pulses", 32'(und_cnt), 32'd1);
        repeat (5) tick();

        // Reset in the middle of DATA, then a fresh frame
        for (int i = 0; i < 20; i++) pay[i] = 8'h40 + 8'(i);
        send_payload(5, 1'b0, 1'b1, lat);
        rst = 1'b1;
        tick();
        check_eq("mid_rst_txv",   32'(mac_txv),  32'd0);
        check_eq("mid_rst_ready", 32'(tx_ready), 32'd0);
        check_eq("mid_rst_busy",  32'(tx_busy),  32'd0);
        tx_valid = 1'b0;
        tick();
        rst = 1'b0;
        repeat (3) tick();
        cap_q.delete();
        pay[0] = 8'h5A; pay[1] = 8'hC3;
        send_payload(2, 1'b1, 1'b0, lat);
        check_eq("fresh_ready_lat", 32'(lat), 32'd8);
        wait_frame_done("fresh");
        check_frame("fresh", 2, 1'b1);

        // Standalone CRC step over ASCII "123456789"
        ref_in = 32'hFFFF_FFFF;
        for (int i = 0; i < 9; i++) begin
            ref_d = 8'h31 + 8'(i);
            #1;
            ref_in = ref_out;
        end
        check_eq("crc_check", ~ref_in, 32'hCBF43926);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
